// File: rtl/scanout_pkg.sv
// ---------------------------------------------------------------------------
// scanout_pkg
// Shared definitions for the frame scan-out controller: the controller state
// enum, default raster timing, the frame buffer address width and the
// colour-bar palette used by the optional test-pattern generator
// (SCANOUT_TEST_PATTERN_EN).
// ---------------------------------------------------------------------------
package scanout_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      VBLANK = 2'd2
   } scanState_t;

   localparam int DEF_H_ACTIVE = 100;
   localparam int DEF_H_FP     = 4;
   localparam int DEF_H_SYNC   = 8;
   localparam int DEF_H_BP     = 4;
   localparam int DEF_V_ACTIVE = 100;
   localparam int DEF_V_FP     = 2;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 2;

   localparam int ADDR_W = 20;

   localparam int NUM_BARS = 8;

   // Colour-bar palette, packed as {R,G,B}.
   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   // Maps a bar index (0 = leftmost) to its {R,G,B} colour.
   function automatic logic [23:0] barColour(input logic [2:0] idx);
      logic [23:0] colour;
      colour = BAR_BLACK;
      case (idx)
         3'd0:    colour = BAR_WHITE;
         3'd1:    colour = BAR_YELLOW;
         3'd2:    colour = BAR_CYAN;
         3'd3:    colour = BAR_GREEN;
         3'd4:    colour = BAR_MAGENTA;
         3'd5:    colour = BAR_RED;
         3'd6:    colour = BAR_BLUE;
         default: colour = BAR_BLACK;
      endcase
      return colour;
   endfunction

endpackage

// File: rtl/scan_timing_gen.sv
// ---------------------------------------------------------------------------
// scan_timing_gen
// Raster position counters for the scan-out controller. Owns the horizontal
// and vertical counters and decodes the raw (unregistered) sync and
// active-area flags from them.
//
// Ports:
//   clk            in   clock, all logic on posedge
//   reset          in   synchronous active-low reset
//   run            in   1 = counters advance, 0 = counters held at 0
//   hCnt           out  horizontal position 0..H_TOTAL-1
//   lineEnd        out  hCnt is on the last cycle of a line
//   frameEnd       out  last cycle of the last line of the frame
//   lastActiveLine out  vCnt is the last visible line
//   hActive        out  hCnt is inside the visible part of the line
//   activeRaw      out  position is inside the visible area
//   hsyncRaw       out  active-low horizontal sync for the current position
//   vsyncRaw       out  active-low vertical sync for the current position
// ---------------------------------------------------------------------------
module scan_timing_gen
   import scanout_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int HCNT_W   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int VCNT_W   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [HCNT_W-1:0] hCnt,
   output logic              lineEnd,
   output logic              frameEnd,
   output logic              lastActiveLine,
   output logic              hActive,
   output logic              activeRaw,
   output logic              hsyncRaw,
   output logic              vsyncRaw
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
   localparam logic [HCNT_W-1:0] H_VIS      = HCNT_W'(H_ACTIVE);
   localparam logic [HCNT_W-1:0] HS_START   = HCNT_W'(H_ACTIVE + H_FP);
   localparam logic [HCNT_W-1:0] HS_END     = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_TOTAL - 1);
   localparam logic [VCNT_W-1:0] V_VIS      = VCNT_W'(V_ACTIVE);
   localparam logic [VCNT_W-1:0] V_VIS_LAST = VCNT_W'(V_ACTIVE - 1);
   localparam logic [VCNT_W-1:0] VS_START   = VCNT_W'(V_ACTIVE + V_FP);
   localparam logic [VCNT_W-1:0] VS_END     = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [VCNT_W-1:0] vCnt;

   // Position decodes. Syncs are active-low: 0 inside the sync window.
   assign lineEnd        = (hCnt == H_LAST);
   assign frameEnd       = lineEnd && (vCnt == V_LAST);
   assign lastActiveLine = (vCnt == V_VIS_LAST);
   assign hActive        = (hCnt < H_VIS);
   assign activeRaw      = hActive && (vCnt < V_VIS);
   assign hsyncRaw       = !((hCnt >= HS_START) && (hCnt < HS_END));
   assign vsyncRaw       = !((vCnt >= VS_START) && (vCnt < VS_END));

   // Raster counters. While the controller is idle they sit at the top-left
   // corner so the first active cycle of a frame is always position (0,0).
   // The line counter steps at the end of every line and wraps with the
   // frame, so consecutive frames follow each other with no gap.
   always_ff @(posedge clk) begin
      if (!reset || !run) begin
         hCnt <= '0;
         vCnt <= '0;
      end else if (lineEnd) begin
         hCnt <= '0;
         vCnt <= frameEnd ? '0 : vCnt + 1'b1;
      end else begin
         hCnt <= hCnt + 1'b1;
      end
   end

endmodule

// File: rtl/frame_scanout.sv
// ---------------------------------------------------------------------------
// frame_scanout
// Display-side scan-out controller for the frame buffer. Reads the buffer in
// raster order, absorbs its one-cycle registered read latency and emits an
// aligned RGB stream with data-enable and active-low syncs. It also tells the
// writer when the buffer may be refilled (no visible pixels left to read).
//
// Optional feature: define SCANOUT_TEST_PATTERN_EN to add the tp_sel input,
// which replaces buffer data with eight vertical colour bars.
//
// Ports:
//   clk                 in   clock, all logic on posedge
//   reset               in   synchronous active-low reset
//   enable              in   permits starting a new frame
//   buf_full            in   buffer holds a complete frame (level)
//   tp_sel              in   select colour bars (SCANOUT_TEST_PATTERN_EN only)
//   RE                  out  buffer read enable
//   Addr                out  buffer read address
//   R_in, G_in, B_in    in   buffer read data, valid one cycle after RE
//   pix_r, pix_g, pix_b out  output pixel
//   de                  out  output pixel valid
//   hsync, vsync        out  active-low syncs, aligned with the pixels
//   buf_empty           out  buffer may be rewritten
//   frame_done          out  one-cycle pulse on the last cycle of a frame
// ---------------------------------------------------------------------------
module frame_scanout
   import scanout_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              buf_full,
`ifdef SCANOUT_TEST_PATTERN_EN
   input  logic              tp_sel,
`endif
   output logic              RE,
   output logic [ADDR_W-1:0] Addr,
   input  logic [7:0]        R_in,
   input  logic [7:0]        G_in,
   input  logic [7:0]        B_in,
   output logic [7:0]        pix_r,
   output logic [7:0]        pix_g,
   output logic [7:0]        pix_b,
   output logic              de,
   output logic              hsync,
   output logic              vsync,
   output logic              buf_empty,
   output logic              frame_done
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HCNT_W  = $clog2(H_TOTAL);
   localparam int VCNT_W  = $clog2(V_TOTAL);

   scanState_t state;
   scanState_t nextState;

   logic [HCNT_W-1:0] hCnt;
   logic              lineEnd;
   logic              frameEnd;
   logic              lastActiveLine;
   logic              hActive;
   logic              activeRaw;
   logic              hsyncRaw;
   logic              vsyncRaw;

   logic              tpMode;
   logic              startOk;
   logic              counting;
   logic              activePix;
   logic [ADDR_W-1:0] rowBase;
   logic [ADDR_W-1:0] addrHold;

`ifdef SCANOUT_TEST_PATTERN_EN
   assign tpMode = tp_sel;
`else
   assign tpMode = 1'b0;
`endif

   // A frame may start only when the display is enabled and there is
   // something to show: a full buffer, or the internal colour bars.
   assign startOk  = enable && (buf_full || tpMode);
   assign counting = (state != IDLE);

   scan_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .HCNT_W   (HCNT_W),
      .VCNT_W   (VCNT_W)
   ) u_timing (
      .clk            (clk),
      .reset          (reset),
      .run            (counting),
      .hCnt           (hCnt),
      .lineEnd        (lineEnd),
      .frameEnd       (frameEnd),
      .lastActiveLine (lastActiveLine),
      .hActive        (hActive),
      .activeRaw      (activeRaw),
      .hsyncRaw       (hsyncRaw),
      .vsyncRaw       (vsyncRaw)
   );

   // Controller state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. enable/buf_full are only looked at when a frame is
   // about to begin, so a buffer that stops being full mid-frame does not cut
   // the frame short. frame_done marks the final blanking cycle, which is
   // also where a back-to-back frame is decided.
   always_comb begin
      nextState  = state;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (startOk) begin
               nextState = SCAN;
            end
         end
         SCAN: begin
            if (lineEnd && lastActiveLine) begin
               nextState = VBLANK;
            end
         end
         VBLANK: begin
            if (frameEnd) begin
               frame_done = 1'b1;
               nextState  = startOk ? SCAN : IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Read-side outputs. The buffer becomes free for refilling as soon as the
   // last visible pixel has been requested, i.e. during the horizontal
   // blanking of the final visible line, not only once VBLANK is reached.
   assign activePix = (state == SCAN) && activeRaw;
   assign RE        = activePix && !tpMode;
   assign Addr      = RE ? (rowBase + ADDR_W'(hCnt)) : addrHold;
   assign buf_empty = tpMode || (state != SCAN) || (lastActiveLine && !hActive);

   // Line base address, advanced by one line width at the end of every
   // visible line so no multiplier is needed. Returns to 0 for the next frame.
   always_ff @(posedge clk) begin
      if (!reset || (state != SCAN)) begin
         rowBase <= '0;
      end else if (lineEnd) begin
         rowBase <= lastActiveLine ? '0 : rowBase + ADDR_W'(H_ACTIVE);
      end
   end

   // Remembers the address presented so it can be held steady while no read
   // is being issued.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addrHold <= '0;
      end else begin
         addrHold <= Addr;
      end
   end

   // One register stage on de and the syncs so they line up with the data
   // the buffer returns one cycle after the read. Syncs stay inactive while
   // idle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         de    <= 1'b0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         de    <= activePix;
         hsync <= counting ? hsyncRaw : 1'b1;
         vsync <= counting ? vsyncRaw : 1'b1;
      end
   end

`ifdef SCANOUT_TEST_PATTERN_EN
   localparam int BAR_W    = (H_ACTIVE / NUM_BARS > 0) ? (H_ACTIVE / NUM_BARS) : 1;
   localparam int BARCNT_W = $clog2(BAR_W + 1);
   localparam logic [BARCNT_W-1:0] BAR_LAST = BARCNT_W'(BAR_W - 1);

   logic [BARCNT_W-1:0] tpPixCnt;
   logic [2:0]          tpBarIdx;
   logic                tpDly;
   logic [23:0]         tpColour;

   // Colour-bar position tracker. It tracks the bar of the pixel currently
   // being issued, restarts at the left edge whenever the raster leaves the
   // visible area, and parks on the last (black) bar for any leftover pixels
   // when the line width is not a multiple of eight.
   always_ff @(posedge clk) begin
      if (!reset || !activePix) begin
         tpPixCnt <= '0;
         tpBarIdx <= '0;
      end else if (tpPixCnt == BAR_LAST) begin
         tpPixCnt <= '0;
         if (tpBarIdx != 3'(NUM_BARS - 1)) begin
            tpBarIdx <= tpBarIdx + 1'b1;
         end
      end else begin
         tpPixCnt <= tpPixCnt + 1'b1;
      end
   end

   // The generated colour goes through the same single register stage as
   // buffer data so both sources share the de/sync alignment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tpDly    <= 1'b0;
         tpColour <= '0;
      end else begin
         tpDly    <= tpMode;
         tpColour <= barColour(tpBarIdx);
      end
   end
`endif

   // Output pixel mux: blanking is forced to black so downstream logic never
   // sees stale buffer data outside the visible area.
   always_comb begin
      pix_r = 8'h00;
      pix_g = 8'h00;
      pix_b = 8'h00;
      if (de) begin
`ifdef SCANOUT_TEST_PATTERN_EN
         if (tpDly) begin
            {pix_r, pix_g, pix_b} = tpColour;
         end else begin
            pix_r = R_in;
            pix_g = G_in;
            pix_b = B_in;
         end
`else
         pix_r = R_in;
         pix_g = G_in;
         pix_b = B_in;
`endif
      end
   end

endmodule

// File: tb/tb_frame_scanout.sv
// ---------------------------------------------------------------------------
// tb_frame_scanout
// Self-checking bench for frame_scanout with default 100x100 timing
// (116 cycles per line, 106 lines per frame). A buffer model returns
// {B,G,R} = address, one cycle after RE. Expected addresses and pixels are
// queued when a frame is requested; a monitor pops and compares them as the
// DUT presents reads and valid pixels, and also checks sync/de/buf_empty/
// frame_done against the raster position since the frame started.
// Test-pattern checks are compiled in with SCANOUT_TEST_PATTERN_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_scanout;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        buf_full;
`ifdef SCANOUT_TEST_PATTERN_EN
   logic        tp_sel;
`endif
   logic        RE;
   logic [19:0] Addr;
   logic [7:0]  R_in, G_in, B_in;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        de, hsync, vsync, buf_empty, frame_done;

   int          vecCount = 0;
   int          errCount = 0;
   bit          monEn    = 0;
   logic [19:0] addrQ[$];
   logic [23:0] pixQ[$];

   frame_scanout dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .buf_full   (buf_full),
`ifdef SCANOUT_TEST_PATTERN_EN
      .tp_sel     (tp_sel),
`endif
      .RE         (RE),
      .Addr       (Addr),
      .R_in       (R_in),
      .G_in       (G_in),
      .B_in       (B_in),
      .pix_r      (pix_r),
      .pix_g      (pix_g),
      .pix_b      (pix_b),
      .de         (de),
      .hsync      (hsync),
      .vsync      (vsync),
      .buf_empty  (buf_empty),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame buffer model: registered read, data = address.
   always @(posedge clk) begin
      if (RE) begin
         {B_in, G_in, R_in} <= {4'h0, Addr};
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic full);
      @(negedge clk);
      enable   = en;
      buf_full = full;
   endtask

   task automatic pushFrame();
      for (int k = 0; k < 10000; k++) begin
         addrQ.push_back(20'(k));
         pixQ.push_back(24'(k));
      end
   endtask

   task automatic waitFrameDone();
      bit seen;
      seen = 0;
      for (int i = 0; i < 13000 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (frame_done) seen = 1;
      end
      checkOutput("frame_done_seen", 32'(seen), 32'd1);
   endtask

   task automatic waitAddr(input logic [19:0] a);
      bit seen;
      seen = 0;
      for (int i = 0; i < 13000 && !seen; i++) begin
         @(negedge clk);
         if (RE && Addr == a) seen = 1;
      end
      checkOutput("addr_reached", 32'(seen), 32'd1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_re"},         32'(RE),                    32'd0);
      checkOutput({tag, "_addr"},       32'(Addr),                  32'd0);
      checkOutput({tag, "_pix"},        32'({pix_r, pix_g, pix_b}), 32'd0);
      checkOutput({tag, "_de"},         32'(de),                    32'd0);
      checkOutput({tag, "_hsync"},      32'(hsync),                 32'd1);
      checkOutput({tag, "_vsync"},      32'(vsync),                 32'd1);
      checkOutput({tag, "_buf_empty"},  32'(buf_empty),             32'd1);
      checkOutput({tag, "_frame_done"}, 32'(frame_done),            32'd0);
   endtask

   task automatic checkStart();
      @(posedge clk);
      #1;
      checkOutput("start_re",   32'(RE),   32'd1);
      checkOutput("start_addr", 32'(Addr), 32'd0);
   endtask

   // Monitor: raster-position checks plus the address/pixel scoreboard.
   int  frameCyc = 0;
   bit  inFrame  = 0;
   int  h, v, ph, pv;
   bit  expDe, expHs, expVs;
   logic [23:0] expPix;
   logic [19:0] expAddr;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!monEn) begin
            inFrame = 0;
         end else begin
            if (!inFrame && RE && Addr == 20'd0) begin
               inFrame  = 1;
               frameCyc = 0;
            end else if (inFrame) begin
               frameCyc++;
            end

            if (inFrame) begin
               h = frameCyc % 116;
               v = frameCyc / 116;
               if (frameCyc == 0) begin
                  expDe = 0; expHs = 1; expVs = 1;
               end else begin
                  ph    = (frameCyc - 1) % 116;
                  pv    = (frameCyc - 1) / 116;
                  expDe = (ph < 100) && (pv < 100);
                  expHs = !((ph >= 104) && (ph < 112));
                  expVs = !((pv >= 102) && (pv < 104));
               end
               checkOutput("frame_re",         32'(RE),         32'((v < 100) && (h < 100)));
               checkOutput("frame_de",         32'(de),         32'(expDe));
               checkOutput("frame_hsync",      32'(hsync),      32'(expHs));
               checkOutput("frame_vsync",      32'(vsync),      32'(expVs));
               checkOutput("frame_buf_empty",  32'(buf_empty),  32'(frameCyc >= 11584));
               checkOutput("frame_frame_done", 32'(frame_done), 32'(frameCyc == 12295));
               if (frameCyc == 12295) inFrame = 0;
            end else begin
               checkOutput("idle_re",         32'(RE),         32'd0);
               checkOutput("idle_de",         32'(de),         32'd0);
               checkOutput("idle_hsync",      32'(hsync),      32'd1);
               checkOutput("idle_vsync",      32'(vsync),      32'd1);
               checkOutput("idle_buf_empty",  32'(buf_empty),  32'd1);
               checkOutput("idle_frame_done", 32'(frame_done), 32'd0);
            end

            if (RE) begin
               checkOutput("addr_queue_nonempty", 32'(addrQ.size() != 0), 32'd1);
               if (addrQ.size() != 0) begin
                  expAddr = addrQ.pop_front();
                  checkOutput("read_addr", 32'(Addr), 32'(expAddr));
               end
            end
            if (de) begin
               checkOutput("pix_queue_nonempty", 32'(pixQ.size() != 0), 32'd1);
               if (pixQ.size() != 0) begin
                  expPix = pixQ.pop_front();
                  checkOutput("pixel_bgr", 32'({pix_b, pix_g, pix_r}), 32'(expPix));
               end
            end else begin
               checkOutput("pixel_blank", 32'({pix_r, pix_g, pix_b}), 32'd0);
            end
         end
      end
   end

`ifdef SCANOUT_TEST_PATTERN_EN
   task automatic runTestPattern();
      bit seenRe;
      bit done;
      int px;
      seenRe = 0;
      done   = 0;
      px     = 0;
      @(negedge clk);
      monEn    = 0;
      tp_sel   = 1;
      enable   = 1;
      buf_full = 0;
      @(posedge clk);
      #1;
      @(negedge clk);
      enable = 0;
      for (int i = 0; i < 13000 && !done; i++) begin
         @(posedge clk);
         #1;
         if (RE) seenRe = 1;
         if (de) begin
            if (px == 0)  checkOutput("tp_pixel0",  32'({pix_r, pix_g, pix_b}), 32'h00FFFFFF);
            if (px == 12) checkOutput("tp_pixel12", 32'({pix_r, pix_g, pix_b}), 32'h00FFFF00);
            if (px == 99) checkOutput("tp_pixel99", 32'({pix_r, pix_g, pix_b}), 32'h00000000);
            px++;
         end
         if (frame_done) done = 1;
      end
      checkOutput("tp_frame_done", 32'(done),      32'd1);
      checkOutput("tp_no_re",      32'(seenRe),    32'd0);
      checkOutput("tp_pix_count",  32'(px),        32'd10000);
      checkOutput("tp_buf_empty",  32'(buf_empty), 32'd1);
      @(negedge clk);
      tp_sel = 0;
   endtask
`endif

   // Main stimulus sequence.
   initial begin
      reset    = 1'b0;
      enable   = 1'b0;
      buf_full = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
      tp_sel   = 1'b0;
`endif

      // Reset held for three cycles, then idle with enable low.
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      @(negedge clk);
      reset = 1'b1;
      monEn = 1;
      applyStimulus(1'b0, 1'b1);
      repeat (20) @(posedge clk);

      // Full frame from a full buffer; enable dropped after the start.
      pushFrame();
      applyStimulus(1'b1, 1'b1);
      checkStart();
      applyStimulus(1'b0, 1'b1);
      waitFrameDone();
      repeat (20) @(posedge clk);
      #1;
      checkOutput("f1_addr_q_empty", 32'(addrQ.size()), 32'd0);
      checkOutput("f1_pix_q_empty",  32'(pixQ.size()),  32'd0);

      // buf_full drops at line 50: frame completes, then back to idle.
      pushFrame();
      applyStimulus(1'b1, 1'b1);
      checkStart();
      waitAddr(20'd5000);
      buf_full = 1'b0;
      waitFrameDone();
      repeat (200) @(posedge clk);
      #1;
      checkOutput("f2_addr_q_empty", 32'(addrQ.size()), 32'd0);
      checkOutput("f2_pix_q_empty",  32'(pixQ.size()),  32'd0);
      applyStimulus(1'b0, 1'b0);

      // Reset asserted at line 30, pixel 40, then a clean restart.
      pushFrame();
      applyStimulus(1'b1, 1'b1);
      checkStart();
      waitAddr(20'd3040);
      monEn = 0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkResetValues("midreset");
      addrQ.delete();
      pixQ.delete();
      @(negedge clk);
      reset  = 1'b1;
      enable = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      monEn = 1;
      pushFrame();
      applyStimulus(1'b1, 1'b1);
      checkStart();
      applyStimulus(1'b0, 1'b1);
      waitFrameDone();
      repeat (20) @(posedge clk);
      #1;
      checkOutput("f3_addr_q_empty", 32'(addrQ.size()), 32'd0);
      checkOutput("f3_pix_q_empty",  32'(pixQ.size()),  32'd0);

`ifdef SCANOUT_TEST_PATTERN_EN
      runTestPattern();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

   // Watchdog so the bench always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: time limit reached, got no completion, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
